// File: rtl/mmio_pkg.sv
// Shared address map defaults and register-select decode for the MMIO button block.
package mmio_pkg;
  localparam logic [31:0] DEF_IN_ADDR         = 32'd1000;
  localparam logic [31:0] DEF_OUT_ADDR        = 32'd2000;
  localparam int          DEF_DEBOUNCE_CYCLES = 4;

  localparam logic [31:0] OFS_LEVEL  = 32'd0;
  localparam logic [31:0] OFS_EDGE   = 32'd1;
  localparam logic [31:0] OFS_OUTPUT = 32'd0;
  localparam logic [31:0] OFS_MASK   = 32'd1;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_LEVEL,
    SEL_EDGE,
    SEL_OUTPUT,
    SEL_MASK
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [31:0] addr,
                                           input logic [31:0] in_base,
                                           input logic [31:0] out_base);
    reg_sel_e sel;
    sel = SEL_RAM;
    if (addr == in_base + OFS_LEVEL)        sel = SEL_LEVEL;
    else if (addr == in_base + OFS_EDGE)    sel = SEL_EDGE;
    else if (addr == out_base + OFS_OUTPUT) sel = SEL_OUTPUT;
    else if (addr == out_base + OFS_MASK)   sel = SEL_MASK;
    return sel;
  endfunction
endpackage

// File: rtl/mmio_debounce.sv
// One button channel: 2-flop synchronizer, stable-count debouncer and rising-edge pulse.
module mmio_debounce import mmio_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_pin,
  output logic o_stable,
  output logic o_rise
);
  localparam int              CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_flip;

  // The flip and the rise pulse land on the same edge, so the sticky bit sets with stable.
  assign w_flip   = (r_sync2 != r_stable) && (r_cnt == CNT_LAST);
  assign o_rise   = w_flip && !r_stable;
  assign o_stable = r_stable;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mmio_button_ctrl.sv
// Memory-mapped button inputs (level + sticky edge, clear-on-read) and output/IRQ-mask registers
// sitting in front of the data RAM.
module mmio_button_ctrl import mmio_pkg::*; #(
  parameter int          NUM_IN          = 4,
  parameter int          NUM_OUT         = 8,
  parameter logic [31:0] IN_ADDR         = DEF_IN_ADDR,
  parameter logic [31:0] OUT_ADDR        = DEF_OUT_ADDR,
  parameter int          DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        address_dmem,
  input  logic               wren,
  input  logic [31:0]        data,
  output logic [31:0]        q_dmem,
  input  logic [31:0]        q_ram,
  output logic               ram_wren,
  input  logic [NUM_IN-1:0]  buttons,
  output logic [NUM_OUT-1:0] outputs,
  output logic               irq
);
  if (NUM_IN < 1 || NUM_IN > 32) begin : g_err_num_in
    $error("mmio_button_ctrl: NUM_IN must be 1..32");
  end
  if (NUM_OUT < 1 || NUM_OUT > 32) begin : g_err_num_out
    $error("mmio_button_ctrl: NUM_OUT must be 1..32");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_err_debounce
    $error("mmio_button_ctrl: DEBOUNCE_CYCLES must be >= 1");
  end
  // 33-bit compare so the +1 cannot wrap and hide an overlap.
  if (({1'b0, IN_ADDR} + 33'd1 >= {1'b0, OUT_ADDR}) &&
      ({1'b0, OUT_ADDR} + 33'd1 >= {1'b0, IN_ADDR})) begin : g_err_overlap
    $error("mmio_button_ctrl: IN_ADDR and OUT_ADDR register pairs overlap");
  end

  logic [NUM_IN-1:0]  w_stable;
  logic [NUM_IN-1:0]  w_rise;
  logic [NUM_IN-1:0]  r_edge;
  logic [NUM_IN-1:0]  r_mask;
  logic [NUM_OUT-1:0] r_outputs;
  logic               r_irq;
  reg_sel_e           w_sel;
  logic               w_hit;
  logic               w_edge_clr;
  logic               w_unused_data;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_btn
    mmio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .i_clock  (clock),
      .i_reset_n(reset),
      .i_pin    (buttons[g]),
      .o_stable (w_stable[g]),
      .o_rise   (w_rise[g])
    );
  end

  assign w_sel         = decode_addr(address_dmem, IN_ADDR, OUT_ADDR);
  assign w_hit         = (w_sel != SEL_RAM);
  assign ram_wren      = wren & ~w_hit;
  assign w_edge_clr    = (w_sel == SEL_EDGE) && !wren;
  assign outputs       = r_outputs;
  assign irq           = r_irq;
  assign w_unused_data = &{1'b0, data};

  always_comb begin
    q_dmem = q_ram;
    case (w_sel)
      SEL_LEVEL:  q_dmem = 32'(w_stable);
      SEL_EDGE:   q_dmem = 32'(r_edge);
      SEL_OUTPUT: q_dmem = 32'(r_outputs);
      SEL_MASK:   q_dmem = 32'(r_mask);
      default:    q_dmem = q_ram;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_edge    <= '0;
      r_mask    <= '0;
      r_outputs <= '0;
      r_irq     <= 1'b0;
    end else begin
      // A rise on the read-clear edge survives the clear.
      r_edge <= (w_edge_clr ? '0 : r_edge) | w_rise;
      if (wren && w_sel == SEL_OUTPUT) r_outputs <= data[NUM_OUT-1:0];
      if (wren && w_sel == SEL_MASK)   r_mask    <= data[NUM_IN-1:0];
      r_irq <= |(r_edge & r_mask);
    end
  end
endmodule

// File: tb/tb_mmio_button_ctrl.sv
// Self-checking bench: reset, register-map vector table, hand-timed debounce/clear/IRQ/reset
// sequences, then random traffic against a behavioural model.
module tb_mmio_button_ctrl;
  localparam int          NI = 4;
  localparam int          NO = 8;
  localparam int          D  = 4;
  localparam logic [31:0] IA = 32'd1000;
  localparam logic [31:0] OA = 32'd2000;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           wren  = 1'b0;
  logic [31:0]    address_dmem = '0;
  logic [31:0]    data  = '0;
  logic [31:0]    q_ram = '0;
  logic [31:0]    q_dmem;
  logic           ram_wren;
  logic           irq;
  logic [NI-1:0]  buttons = '0;
  logic [NO-1:0]  outputs;

  int checks = 0;
  int errors = 0;

  mmio_button_ctrl #(
    .NUM_IN(NI), .NUM_OUT(NO), .IN_ADDR(IA), .OUT_ADDR(OA), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .wren(wren), .data(data),
    .q_dmem(q_dmem), .q_ram(q_ram), .ram_wren(ram_wren), .buttons(buttons),
    .outputs(outputs), .irq(irq)
  );

  always #5 clock = ~clock;

  // Behavioural model: pins reach the debouncer two samples late; a level flips once the
  // opposite value has been seen D samples in a row.
  logic [NI-1:0] m_p1, m_p2, m_stable, m_edge, m_mask;
  logic [NO-1:0] m_out;
  logic          m_irq;
  int            m_run [NI];

  task automatic model_update();
    logic [NI-1:0] rise;
    logic          nirq;
    rise = '0;
    nirq = |(m_edge & m_mask);
    if (!reset) begin
      m_p1 = '0; m_p2 = '0; m_stable = '0; m_edge = '0; m_mask = '0; m_out = '0; m_irq = 1'b0;
      for (int i = 0; i < NI; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (m_p2[i] == m_stable[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_stable[i] = m_p2[i];
            m_run[i]    = 0;
            rise[i]     = m_p2[i];
          end
        end
      end
      m_p2 = m_p1;
      m_p1 = buttons;
      if (address_dmem == IA + 32'd1 && !wren) m_edge = '0;
      m_edge = m_edge | rise;
      if (wren && address_dmem == OA)         m_out  = data[NO-1:0];
      if (wren && address_dmem == OA + 32'd1) m_mask = data[NI-1:0];
      m_irq = nirq;
    end
  endtask

  function automatic logic [31:0] model_q();
    if (address_dmem == IA)              return 32'(m_stable);
    if (address_dmem == IA + 32'd1)      return 32'(m_edge);
    if (address_dmem == OA)              return 32'(m_out);
    if (address_dmem == OA + 32'd1)      return 32'(m_mask);
    return q_ram;
  endfunction

  function automatic logic model_hit();
    return address_dmem == IA || address_dmem == IA + 32'd1 ||
           address_dmem == OA || address_dmem == OA + 32'd1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic peek(input logic [31:0] addr, output logic [31:0] val);
    logic [31:0] sa;
    logic        sw;
    sa = address_dmem; sw = wren;
    address_dmem = addr; wren = 1'b0;
    #1;
    val = q_dmem;
    address_dmem = sa; wren = sw;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] qram;
    logic [31:0] exp_q;
    logic        exp_rw;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] v;

  initial begin
    vecs.push_back('{32'd500,  1'b1, 32'h1234,     32'hDEADBEEF, 32'hDEADBEEF, 1'b1});
    vecs.push_back('{32'd500,  1'b0, 32'h0,        32'h12345678, 32'h12345678, 1'b0});
    vecs.push_back('{IA,       1'b1, 32'hFFFFFFFF, 32'h00001111, 32'h0,        1'b0});
    vecs.push_back('{IA+1,     1'b1, 32'hFFFFFFFF, 32'h00002222, 32'h0,        1'b0});
    vecs.push_back('{IA,       1'b0, 32'h0,        32'h00003333, 32'h0,        1'b0});
    vecs.push_back('{OA,       1'b1, 32'h000001C3, 32'h00004444, 32'h0,        1'b0});
    vecs.push_back('{OA,       1'b0, 32'h0,        32'h00005555, 32'hC3,       1'b0});
    vecs.push_back('{OA+1,     1'b1, 32'hFFFFFFF6, 32'h00006666, 32'h0,        1'b0});
    vecs.push_back('{OA+1,     1'b0, 32'h0,        32'h00007777, 32'h6,        1'b0});
    vecs.push_back('{OA-1,     1'b1, 32'h0,        32'hA0A0A0A0, 32'hA0A0A0A0, 1'b1});
    vecs.push_back('{OA+2,     1'b1, 32'h0,        32'hB1B1B1B1, 32'hB1B1B1B1, 1'b1});
    vecs.push_back('{IA-1,     1'b1, 32'h0,        32'hC2C2C2C2, 32'hC2C2C2C2, 1'b1});
    vecs.push_back('{IA+2,     1'b0, 32'h0,        32'hD3D3D3D3, 32'hD3D3D3D3, 1'b0});
    vecs.push_back('{OA+1,     1'b1, 32'h0,        32'h0,        32'h6,        1'b0});
    vecs.push_back('{OA,       1'b1, 32'h0,        32'h0,        32'hC3,       1'b0});

    // Reset dominates a same-cycle write; combinational paths stay live.
    reset = 1'b0; buttons = 4'hF; wren = 1'b1; address_dmem = OA; data = 32'hFF;
    step(); step();
    chk("rst_outputs", outputs, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ram_wren", ram_wren, 0);
    chk("rst_q_out", q_dmem, 0);
    peek(IA + 1, v); chk("rst_edge", v, 0);
    peek(IA, v);     chk("rst_level", v, 0);
    reset = 1'b1; buttons = '0; wren = 1'b0; address_dmem = '0; data = '0;
    step();

    foreach (vecs[k]) begin
      address_dmem = vecs[k].addr; wren = vecs[k].wr; data = vecs[k].wdata; q_ram = vecs[k].qram;
      #1;
      chk($sformatf("vec%0d_q", k), q_dmem, vecs[k].exp_q);
      chk($sformatf("vec%0d_rw", k), ram_wren, vecs[k].exp_rw);
      step();
    end
    address_dmem = '0; wren = 1'b0; data = '0; q_ram = '0;
    chk("vec_outputs_cleared", outputs, 0);

    // Debounce latency: level appears on the 2+D-th edge after the change.
    buttons[0] = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step();
      if (n == 5) begin peek(IA, v); chk("deb_level_early", v, 0); end
    end
    peek(IA, v);     chk("deb_level", v, 1);
    peek(IA + 1, v); chk("deb_edge", v, 1);

    // Short glitch never reaches stable.
    buttons[1] = 1'b1; step(); step(); buttons[1] = 1'b0;
    repeat (8) step();
    peek(IA, v);     chk("glitch_level", v, 1);
    peek(IA + 1, v); chk("glitch_edge", v, 1);

    // Clear-on-read, and a rise on the clearing edge wins.
    buttons[1] = 1'b1;
    repeat (6) step();
    peek(IA + 1, v); chk("cor_before", v, 3);
    address_dmem = IA + 1; #1;
    chk("cor_read", q_dmem, 3);
    step();
    chk("cor_after", q_dmem, 0);
    address_dmem = '0;
    buttons[2] = 1'b1;
    repeat (5) step();
    address_dmem = IA + 1; #1;
    chk("cor_pre_set", q_dmem, 0);
    step();
    address_dmem = '0;
    peek(IA + 1, v); chk("cor_set_wins", v, 4);

    // Output register, mask and IRQ latency.
    address_dmem = OA; wren = 1'b1; data = 32'hA5; #1;
    chk("out_wr_ram_wren", ram_wren, 0);
    step();
    address_dmem = OA + 1; data = 32'h1;
    step();
    wren = 1'b0; address_dmem = '0; data = '0;
    chk("out_value", outputs, 8'hA5);
    peek(OA, v);     chk("out_readback", v, 32'hA5);
    peek(OA + 1, v); chk("mask_readback", v, 1);
    step();
    chk("irq_masked_off", irq, 0);
    buttons[0] = 1'b0;
    repeat (8) step();
    buttons[0] = 1'b1;
    repeat (6) step();
    chk("irq_same_edge", irq, 0);
    step();
    chk("irq_set", irq, 1);
    address_dmem = IA + 1;
    step();
    chk("irq_clear_edge", irq, 1);
    address_dmem = '0;
    step();
    chk("irq_cleared", irq, 0);

    // Reset two counts into a debounce restarts the whole delay.
    buttons = 4'hF;
    repeat (4) step();
    peek(IA, v); chk("mid_partial", v, 7);
    reset = 1'b0; step(); reset = 1'b1;
    chk("mid_outputs", outputs, 0);
    peek(IA, v); chk("mid_level_rst", v, 0);
    repeat (5) step();
    peek(IA, v); chk("mid_level_early", v, 0);
    step();
    peek(IA, v); chk("mid_level", v, 4'hF);

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 79) != 0);
      for (int b = 0; b < NI; b++)
        if ($urandom_range(0, 7) == 0) buttons[b] = ~buttons[b];
      case ($urandom_range(0, 5))
        0:       address_dmem = IA;
        1:       address_dmem = IA + 32'd1;
        2:       address_dmem = OA;
        3:       address_dmem = OA + 32'd1;
        default: address_dmem = 32'($urandom_range(0, 3000));
      endcase
      wren = 1'($urandom_range(0, 1));
      data = $urandom; q_ram = $urandom;
      #1;
      chk("rnd_q", q_dmem, model_q());
      chk("rnd_ram_wren", ram_wren, wren && !model_hit());
      chk("rnd_outputs", outputs, m_out);
      chk("rnd_irq", irq, m_irq);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_button_ctrl.md
MMIO_BUTTON_CTRL -- requirements
Module: mmio_button_ctrl

Interface
REQ-001 SHALL have parameters: NUM_IN, default 4, number of button inputs (1..32).
REQ-002 SHALL have parameter NUM_OUT, default 8, number of output bits (1..32).
REQ-003 SHALL have parameter IN_ADDR, default 1000, word address of the level register; IN_ADDR+1 is the edge register.
REQ-004 SHALL have parameter OUT_ADDR, default 2000, word address of the output register; OUT_ADDR+1 is the IRQ mask register.
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 4, stable-cycle count (>=1).
REQ-006 SHALL have ports: clock in 1, sole clock; reset in 1, synchronous active-low; one clock, and reset is synchronous and active-low.
REQ-007 SHALL have ports: address_dmem in 32, processor data address; wren in 1, processor write enable; data in 32, processor write data.
REQ-008 SHALL have ports: q_dmem out 32, read data to processor; q_ram in 32, RAM read data; ram_wren out 1, gated RAM write enable.
REQ-009 SHALL have ports: buttons in NUM_IN, asynchronous pins; outputs out NUM_OUT, output register; irq out 1, level interrupt.

Function
REQ-010 SHALL define hit = address_dmem in {IN_ADDR, IN_ADDR+1, OUT_ADDR, OUT_ADDR+1}; ram_wren = wren & !hit, combinational.
REQ-011 SHALL drive q_dmem combinationally, in the same cycle as the address: level register at IN_ADDR, edge register at IN_ADDR+1, outputs at OUT_ADDR, mask at OUT_ADDR+1, else q_ram; all fields zero-extended to 32 bits.
REQ-012 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-013 SHALL keep per-channel stable level and counter: if sync==stable, cnt<=0; else if cnt==DEBOUNCE_CYCLES-1, stable<=sync and cnt<=0; else cnt<=cnt+1.
REQ-014 SHALL therefore update stable exactly 2+DEBOUNCE_CYCLES rising edges after a pin level change held constant; a glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL not change stable.
REQ-015 SHALL set sticky edge bit i on the edge where stable[i] goes 0->1.
REQ-016 SHALL clear the whole edge register on a clock edge with address_dmem==IN_ADDR+1 and wren==0 (clear-on-read); a new rising edge in that same cycle SHALL set its bit (set wins over clear).
REQ-017 SHALL, on wren==1 at OUT_ADDR, load outputs<=data[NUM_OUT-1:0]; at OUT_ADDR+1, load mask<=data[NUM_IN-1:0]; writes to IN_ADDR or IN_ADDR+1 SHALL be ignored and SHALL not clear edges.
REQ-018 SHALL drive irq = |(edge & mask), registered (one-cycle latency after edge/mask update).
REQ-019 SHALL treat IN_ADDR/OUT_ADDR ranges overlapping as a parameter error (elaboration-time check).

Reset
REQ-020 SHALL, on a rising clock edge with reset==0, clear synchronizers, stable, counters, edge, mask, outputs and irq to 0.
REQ-021 SHALL make reset dominate every same-cycle write, clear or edge event; reset mid-debounce SHALL discard the partial count.
REQ-022 SHALL keep combinational outputs (q_dmem, ram_wren) functional during reset, reflecting the cleared registers.

Structure
REQ-023 SHALL place default IN_ADDR, OUT_ADDR, DEBOUNCE_CYCLES and the address-offset constants in shared package mmio_pkg.
REQ-024 SHALL implement synchronizer+debounce+edge detect as one sub-module mmio_debounce, instantiated NUM_IN times via generate.
REQ-025 SHALL use no latches and no clock other than clock.

Verification
REQ-026 Reset: hold reset=0 two cycles with buttons=4'hF, wren=1 at 2000 -> outputs=0, irq=0, edge=0, q_dmem@1000=0.
REQ-027 Debounce: raise buttons[0] at edge 10, hold -> q_dmem@1000 reads 1 from edge 16 (DEBOUNCE_CYCLES=4), edge@1001=1; 2-cycle pulse on buttons[1] -> level and edge stay 0.
REQ-028 Clear-on-read: edge=4'b0011, read 1001 one cycle -> q_dmem=3 that cycle, 0 next; new edge on bit2 in read cycle -> next read returns 4.
REQ-029 Outputs/IRQ: write 32'hA5 to 2000, 32'h1 to 2001 -> outputs=8'hA5, readback 0xA5; edge on bit0 -> irq=1 one cycle later, clear by read -> irq=0.
REQ-030 Passthrough: write 32'h1234 to 500 -> ram_wren=1, q_dmem=q_ram; write to 1000 -> ram_wren=0, level register unchanged.
REQ-031 Reset mid-operation: assert reset during debounce count 2 -> stable stays 0, full 2+DEBOUNCE_CYCLES delay restarts after release.
